// File: rtl/pe_mem_banked.sv
// pe_mem_banked
//   Multi-bank local word memory for a processing element. Each bank is an
//   independent array of 2**ADDR_WIDTH words. Writes either overwrite or
//   accumulate (modulo 2**WORD_SIZE). Reads are registered with one cycle of
//   latency and a valid flag. A clear sequencer zeroes one word index across
//   all banks per cycle after reset or on clr_req.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   clr_req    restart the clear sequence (ignored while init_busy)
//   init_busy  high while the clear sequence runs
//   wr_en      write strobe
//   wr_acc     1: accumulate into the word, 0: overwrite the word
//   wr_bank    write bank select
//   wr_addr    write word address
//   wr_data    write data
//   rd_en      read strobe
//   rd_bank    read bank select
//   rd_addr    read word address
//   rd_data    registered read data
//   rd_valid   rd_data was updated by a read on this edge

module pe_mem_banked #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned NUM_BANKS  = 2,
    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  init_busy,
    input  logic                  wr_en,
    input  logic                  wr_acc,
    input  logic [BANK_BITS-1:0]  wr_bank,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0]  wr_data,
    input  logic                  rd_en,
    input  logic [BANK_BITS-1:0]  rd_bank,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_SIZE-1:0]  rd_data,
    output logic                  rd_valid
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    logic [WORD_SIZE-1:0] mem [0:NUM_BANKS-1][0:DEPTH-1];

    // Control FSM with registered outputs. The read port samples the array
    // before this edge's write lands, which gives read-first ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= StInit;
            clr_cnt   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            init_busy <= 1'b1;
        end else begin
            unique case (state)
                StInit: begin
                    rd_valid <= 1'b0;
                    clr_cnt  <= clr_cnt + 1'b1;
                    if (clr_cnt == LastAddr) begin
                        state     <= StRun;
                        init_busy <= 1'b0;
                    end
                end
                StRun: begin
                    rd_valid <= rd_en;
                    if (rd_en) begin
                        rd_data <= mem[rd_bank][rd_addr];
                    end
                    if (clr_req) begin
                        state     <= StInit;
                        clr_cnt   <= '0;
                        init_busy <= 1'b1;
                    end
                end
                default: begin
                    state     <= StInit;
                    clr_cnt   <= '0;
                    init_busy <= 1'b1;
                    rd_valid  <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; only the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == StInit) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    mem[BANK_BITS'(b)][clr_cnt] <= '0;
                end
            end else if (wr_en) begin
                if (wr_acc) begin
                    mem[wr_bank][wr_addr] <= mem[wr_bank][wr_addr] + wr_data;
                end else begin
                    mem[wr_bank][wr_addr] <= wr_data;
                end
            end
        end
    end

endmodule
